watch_time_editor: RTL
======================

# watch_time_editor

Parametrised successor to the watch set-mode screen. Edits year/month/day/hour/minute/second with per-field range limits, calendar-correct day wrap (leap years included), and hold-to-repeat on increment/decrement. It drives the 32-character LCD stream by index and hands committed time to the timekeeping core as a one-cycle load strobe. It sits between the debounced button block, the LCD controller (`index`/`out`) and the watch counter (`bin_time`/`en_time`).

## Interface
Parameters:
- `BLINK_DIV`, 25_000_000: clk cycles per blink half-period.
- `REPEAT_DELAY`, 12_500_000: clk cycles a held inc/dec must stay high before auto-repeat starts.
- `REPEAT_RATE`, 2_500_000: clk cycles between auto-repeat steps.
- `ARROW_CHAR`, 8'h7E: glyph shown at the commit position.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `btn_next` input 1: debounced level; cursor right.
- `btn_prev` input 1: debounced level; cursor left.
- `btn_inc` input 1: debounced level; increment field, or commit at cursor 6.
- `btn_dec` input 1: debounced level; decrement field.
- `load` input 1: one-cycle pulse; copy `cur_time` into the edit registers.
- `cur_time` input 48: {year, month, day, hour, minute, second}, 8-bit binary each, year at [47:40].
- `index` input 5: LCD character position 0–31.
- `out` output 8: ASCII for `index`, registered.
- `bin_time` output 48: committed time, same packing as `cur_time`.
- `en_time` output 1: one-cycle commit strobe.

## Operation
- Edit registers: `yr` 0–99 (displayed as 20yy), `mo` 1–12, `dy` 1–dim(mo,yr), `hr` 0–23, `mi` 0–59, `se` 0–59.
- dim: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February is 29 when `yr%4==0`, else 28.
- Cursor 0..6 maps to yr, mo, dy, hr, mi, se, commit. It saturates at 0 and 6 and does not wrap.
- Buttons are rising-edge detected internally. Only one action per cycle. Priority: `load` > next > prev > inc > dec.
- inc/dec wrap within the field range: 59→0, 0→59, mo 12→1, 1→12, dy dim→1, 1→dim.
- After any mo or yr change, including `load`, `dy` is clamped to min(`dy`, dim(new mo, new yr)).
- Auto-repeat: while inc (or dec) stays high with no other button pressed, the first step happens on the edge. After `REPEAT_DELAY` cycles a step repeats every `REPEAT_RATE` cycles. Releasing the button or any cursor move clears the repeat counter. There is no repeat at cursor 6.
- Commit: an inc edge at cursor 6 loads `bin_time` from the edit registers in `cur_time` packing order and pulses `en_time`. The cursor stays at 6.
- `load`: copies `cur_time` and sets cursor to 0. Any out-of-range field is replaced by its minimum (0, or 1 for mo/dy).
- Blink: a free-running counter toggles `blink` every `BLINK_DIV` cycles. When `blink`=1, the characters of the field under the cursor are output as 8'h20.
- Display map:
  - 0–4: "SET  "
  - 5–6: "20"
  - 7–8: yr
  - 9: 'Y'
  - 10–11: mo
  - 12: 'M'
  - 13–14: dy
  - 15: 'D'
  - 16–20: "TIME "
  - 21–22: hr
  - 23: 'H'
  - 24–25: mi
  - 26: 'M'
  - 27–28: se
  - 29: 'S'
  - 30: ' '
  - 31: `ARROW_CHAR`
- Digits are 8'h30 plus the tens or ones of the field (binary to two decimal digits, combinational). Year blinks at positions 5–8.

## Timing
- Reset values: `out`=8'h20, `bin_time`=0, `en_time`=0, cursor=0, `blink`=0, repeat and blink counters 0.
- Edit register reset values: `yr`=0, `mo`=1, `dy`=1, `hr`=`mi`=`se`=0.
- `out` latency: 1 cycle after `index` is sampled.
- A button edge sampled at cycle n updates the register at the n+1 edge, so the new `out` is visible at n+2.
- `en_time` is high for exactly the one cycle after the commit edge. `bin_time` is valid in that same cycle and held until the next commit.
- Reset during an edit or a repeat discards all edits. `bin_time` returns to 0 with no `en_time`.
- `load` coincident with a button edge: `load` wins and the button edge is dropped.

## Test plan
- Reset, then sweep index 0–31 → "SET  2000Y01M01D" / "TIME 00H00M00S " + 8'h7E, each one cycle after its index.
- `load` 2024-02-29 23:59:59, cursor to yr, dec → yr=23 and dy clamps to 28. inc → yr=24, dy stays 28.
- Cursor to se, inc from 59 → 0. dec from 0 → 59. Cursor to mo, inc from 12 → 1.
- Hold `btn_inc` on mi for REPEAT_DELAY+3·REPEAT_RATE cycles (small parameter values) → exactly 4 increments.
- Press next ×8 → cursor 6. Press inc → `bin_time`={yr,mo,dy,hr,mi,se} and `en_time` high for 1 cycle. Pressing prev at cursor 0 → stays 0.
- `blink`=1 with cursor=3 → indices 21 and 22 output 8'h20 while index 23 outputs 'H'. Assert `rst` mid-repeat → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/watch_time_editor.sv
`default_nettype none
// ============================================================================
//  Module   : watch_time_editor
//  Purpose  : Set-mode editor for the watch. Holds editable year/month/day/
//             hour/minute/second registers with per-field wrap limits and a
//             calendar-correct day range. Supports hold-to-repeat on inc/dec
//             and renders the 32-character LCD line by index. A commit hands
//             the edited time to the timekeeping core.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             btn_next/btn_prev  - debounced levels, cursor right/left
//             btn_inc/btn_dec    - debounced levels, field +/- (inc commits
//                                  at cursor 6)
//             load, cur_time     - pulse that copies cur_time into the editor
//             index, out         - LCD character position / registered ASCII
//             bin_time, en_time  - committed time and its one-cycle strobe
//  Revision : 1.0 - initial release
// ============================================================================
module watch_time_editor #(
  parameter int         BLINK_DIV    = 25_000_000,
  parameter int         REPEAT_DELAY = 12_500_000,
  parameter int         REPEAT_RATE  = 2_500_000,
  parameter logic [7:0] ARROW_CHAR   = 8'h7E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        load,
  input  logic [47:0] cur_time,
  input  logic [4:0]  index,
  output logic [7:0]  out,
  output logic [47:0] bin_time,
  output logic        en_time
);

  localparam int         c_rep_w    = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int         c_blk_w    = $clog2(BLINK_DIV + 1);
  localparam logic [2:0] c_cur_yr   = 3'd0;
  localparam logic [2:0] c_cur_mo   = 3'd1;
  localparam logic [2:0] c_cur_dy   = 3'd2;
  localparam logic [2:0] c_cur_hr   = 3'd3;
  localparam logic [2:0] c_cur_mi   = 3'd4;
  localparam logic [2:0] c_cur_se   = 3'd5;
  localparam logic [2:0] c_cur_cmt  = 3'd6;
  localparam logic [2:0] c_cur_none = 3'd7;

  // Days in month; every fourth year is leap within the 2000-2099 range.
  function automatic logic [7:0] dim(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
      8'd2:                    return (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
      default:                 return 8'd31;
    endcase
  endfunction

  function automatic logic [7:0] tens(input logic [7:0] v);
    return 8'h30 + (v / 8'd10);
  endfunction

  function automatic logic [7:0] ones(input logic [7:0] v);
    return 8'h30 + (v % 8'd10);
  endfunction

  logic [7:0] r_yr, r_mo, r_dy, r_hr, r_mi, r_se;
  logic [2:0] r_cursor;
  logic       r_blink;
  logic [c_blk_w-1:0] r_blk_cnt;
  logic [c_rep_w-1:0] r_rep_cnt;
  logic r_next_s, r_next_d, r_prev_s, r_prev_d;
  logic r_inc_s, r_inc_d, r_dec_s, r_dec_d, r_load_s;

  logic w_next_edge, w_prev_edge, w_inc_edge, w_dec_edge;
  logic w_inc_hold, w_dec_hold, w_hold, w_rep_fire, w_step_inc, w_step_dec;
  logic [c_rep_w-1:0] w_cnt_inc;
  logic [7:0] w_yr_n, w_mo_n, w_dy_t, w_dy_n, w_hr_n, w_mi_n, w_se_n;
  logic [7:0] w_dim_cur, w_dim_n, w_char;
  logic [2:0] w_cur_n, w_field;
  logic       w_commit;

  // Inputs pass through one register stage before edge detection, so an
  // edge sampled at one clock takes effect at the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_next_s, r_next_d, r_prev_s, r_prev_d} <= 4'b0;
      {r_inc_s, r_inc_d, r_dec_s, r_dec_d}     <= 4'b0;
      r_load_s                                 <= 1'b0;
    end else begin
      r_next_s <= btn_next;  r_next_d <= r_next_s;
      r_prev_s <= btn_prev;  r_prev_d <= r_prev_s;
      r_inc_s  <= btn_inc;   r_inc_d  <= r_inc_s;
      r_dec_s  <= btn_dec;   r_dec_d  <= r_dec_s;
      r_load_s <= load;
    end
  end

  assign w_next_edge = r_next_s & ~r_next_d;
  assign w_prev_edge = r_prev_s & ~r_prev_d;
  assign w_inc_edge  = r_inc_s & ~r_inc_d;
  assign w_dec_edge  = r_dec_s & ~r_dec_d;

  // A hold only counts after its edge cycle and only while it is the sole
  // button down; anything else restarts the repeat timing from zero.
  assign w_inc_hold = r_inc_s & r_inc_d & ~r_dec_s & ~r_next_s & ~r_prev_s;
  assign w_dec_hold = r_dec_s & r_dec_d & ~r_inc_s & ~r_next_s & ~r_prev_s;
  assign w_hold     = (w_inc_hold | w_dec_hold) & ~r_load_s & (r_cursor != c_cur_cmt);
  assign w_cnt_inc  = r_rep_cnt + 1'b1;
  // Steps fire at DELAY, DELAY+RATE, ... cycles after the edge; the counter
  // folds back to DELAY after each RATE period.
  assign w_rep_fire = w_hold & ((w_cnt_inc == c_rep_w'(REPEAT_DELAY)) ||
                                (w_cnt_inc == c_rep_w'(REPEAT_DELAY + REPEAT_RATE)));
  assign w_step_inc = w_inc_edge | (w_rep_fire & w_inc_hold);
  assign w_step_dec = w_dec_edge | (w_rep_fire & w_dec_hold);

  always_ff @(posedge clk) begin
    if (rst || !w_hold)
      r_rep_cnt <= '0;
    else if (w_cnt_inc == c_rep_w'(REPEAT_DELAY + REPEAT_RATE))
      r_rep_cnt <= c_rep_w'(REPEAT_DELAY);
    else
      r_rep_cnt <= w_cnt_inc;
  end

  assign w_dim_cur = dim(r_mo, r_yr);

  // Next-value computation for the edit registers, one action per cycle.
  always_comb begin
    w_yr_n   = r_yr;
    w_mo_n   = r_mo;
    w_dy_t   = r_dy;
    w_hr_n   = r_hr;
    w_mi_n   = r_mi;
    w_se_n   = r_se;
    w_cur_n  = r_cursor;
    w_commit = 1'b0;
    if (r_load_s) begin
      w_yr_n  = (cur_time[47:40] > 8'd99) ? 8'd0 : cur_time[47:40];
      w_mo_n  = (cur_time[39:32] == 8'd0 || cur_time[39:32] > 8'd12) ? 8'd1 : cur_time[39:32];
      w_dy_t  = (cur_time[31:24] == 8'd0 || cur_time[31:24] > 8'd31) ? 8'd1 : cur_time[31:24];
      w_hr_n  = (cur_time[23:16] > 8'd23) ? 8'd0 : cur_time[23:16];
      w_mi_n  = (cur_time[15:8]  > 8'd59) ? 8'd0 : cur_time[15:8];
      w_se_n  = (cur_time[7:0]   > 8'd59) ? 8'd0 : cur_time[7:0];
      w_cur_n = c_cur_yr;
    end else if (w_next_edge) begin
      if (r_cursor != c_cur_cmt) w_cur_n = r_cursor + 3'd1;
    end else if (w_prev_edge) begin
      if (r_cursor != c_cur_yr) w_cur_n = r_cursor - 3'd1;
    end else if (w_step_inc) begin
      case (r_cursor)
        c_cur_yr:  w_yr_n = (r_yr == 8'd99) ? 8'd0 : r_yr + 8'd1;
        c_cur_mo:  w_mo_n = (r_mo == 8'd12) ? 8'd1 : r_mo + 8'd1;
        c_cur_dy:  w_dy_t = (r_dy >= w_dim_cur) ? 8'd1 : r_dy + 8'd1;
        c_cur_hr:  w_hr_n = (r_hr == 8'd23) ? 8'd0 : r_hr + 8'd1;
        c_cur_mi:  w_mi_n = (r_mi == 8'd59) ? 8'd0 : r_mi + 8'd1;
        c_cur_se:  w_se_n = (r_se == 8'd59) ? 8'd0 : r_se + 8'd1;
        c_cur_cmt: w_commit = w_inc_edge;
        default:   ;
      endcase
    end else if (w_step_dec) begin
      case (r_cursor)
        c_cur_yr:  w_yr_n = (r_yr == 8'd0) ? 8'd99 : r_yr - 8'd1;
        c_cur_mo:  w_mo_n = (r_mo <= 8'd1) ? 8'd12 : r_mo - 8'd1;
        c_cur_dy:  w_dy_t = (r_dy <= 8'd1) ? w_dim_cur : r_dy - 8'd1;
        c_cur_hr:  w_hr_n = (r_hr == 8'd0) ? 8'd23 : r_hr - 8'd1;
        c_cur_mi:  w_mi_n = (r_mi == 8'd0) ? 8'd59 : r_mi - 8'd1;
        c_cur_se:  w_se_n = (r_se == 8'd0) ? 8'd59 : r_se - 8'd1;
        default:   ;
      endcase
    end
    // Clamping every cycle covers month, year and load changes in one place.
    w_dim_n = dim(w_mo_n, w_yr_n);
    w_dy_n  = (w_dy_t > w_dim_n) ? w_dim_n : w_dy_t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_yr     <= 8'd0;
      r_mo     <= 8'd1;
      r_dy     <= 8'd1;
      r_hr     <= 8'd0;
      r_mi     <= 8'd0;
      r_se     <= 8'd0;
      r_cursor <= c_cur_yr;
      bin_time <= 48'd0;
      en_time  <= 1'b0;
    end else begin
      r_yr     <= w_yr_n;
      r_mo     <= w_mo_n;
      r_dy     <= w_dy_n;
      r_hr     <= w_hr_n;
      r_mi     <= w_mi_n;
      r_se     <= w_se_n;
      r_cursor <= w_cur_n;
      en_time  <= w_commit;
      if (w_commit) bin_time <= {r_yr, r_mo, r_dy, r_hr, r_mi, r_se};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b0;
    end else if (r_blk_cnt == c_blk_w'(BLINK_DIV - 1)) begin
      r_blk_cnt <= '0;
      r_blink   <= ~r_blink;
    end else begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  // Character map; w_field tags which cursor position owns the character.
  always_comb begin
    w_char  = 8'h20;
    w_field = c_cur_none;
    case (index)
      5'd0:  w_char = "S";
      5'd1:  w_char = "E";
      5'd2:  w_char = "T";
      5'd5:  begin w_char = "2";        w_field = c_cur_yr;  end
      5'd6:  begin w_char = "0";        w_field = c_cur_yr;  end
      5'd7:  begin w_char = tens(r_yr); w_field = c_cur_yr;  end
      5'd8:  begin w_char = ones(r_yr); w_field = c_cur_yr;  end
      5'd9:  w_char = "Y";
      5'd10: begin w_char = tens(r_mo); w_field = c_cur_mo;  end
      5'd11: begin w_char = ones(r_mo); w_field = c_cur_mo;  end
      5'd12: w_char = "M";
      5'd13: begin w_char = tens(r_dy); w_field = c_cur_dy;  end
      5'd14: begin w_char = ones(r_dy); w_field = c_cur_dy;  end
      5'd15: w_char = "D";
      5'd16: w_char = "T";
      5'd17: w_char = "I";
      5'd18: w_char = "M";
      5'd19: w_char = "E";
      5'd21: begin w_char = tens(r_hr); w_field = c_cur_hr;  end
      5'd22: begin w_char = ones(r_hr); w_field = c_cur_hr;  end
      5'd23: w_char = "H";
      5'd24: begin w_char = tens(r_mi); w_field = c_cur_mi;  end
      5'd25: begin w_char = ones(r_mi); w_field = c_cur_mi;  end
      5'd26: w_char = "M";
      5'd27: begin w_char = tens(r_se); w_field = c_cur_se;  end
      5'd28: begin w_char = ones(r_se); w_field = c_cur_se;  end
      5'd29: w_char = "S";
      5'd31: begin w_char = ARROW_CHAR; w_field = c_cur_cmt; end
      default: ;
    endcase
    if (r_blink && (w_field == r_cursor)) w_char = 8'h20;
  end

  always_ff @(posedge clk) begin
    if (rst) out <= 8'h20;
    else     out <= w_char;
  end

endmodule
`default_nettype wire
